dac_spi_tx: RTL and testbench

- SPI master transmitter that serializes one DAC frame per request (DAC121S101-style: 16-bit frame, MSB first, SYNC active-low).
- Sits directly downstream of the bench/board clock generator: consumes the 100 MHz master clock and derives SCLK internally via a clock-enable counter. It never generates a second clock domain.
- Feeds the external DAC pins, and is driven by a start/busy/done handshake from the sample-producing logic.

---
 rtl/dac_spi_tx.sv | 139 +++++++++++++
 tb/tb_dac_spi_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// SPI master transmitter for a DAC121S101-style converter: one DATA_WIDTH-bit frame, MSB first, SYNC active-low.
// Latency: busy is high for (2*DATA_WIDTH+1)*SCLK_DIV + 1 clk cycles per frame (133 cycles at the default parameters).
// Backpressure: start is sampled only in IDLE; a start seen while busy is dropped, not queued.
// Optional build macro DAC_SPI_TX_FRAME_COUNT_EN adds a 16-bit frame_cnt output that counts completed frames.
module dac_spi_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int SCLK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  sync_n,
  output logic                  sdo
`ifdef DAC_SPI_TX_FRAME_COUNT_EN
  ,
  output logic [15:0]           frame_cnt
`endif
);

  localparam int HW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [HW-1:0] HLAST = HW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [HW-1:0]         hcnt, hcnt_nxt;
  logic [BW-1:0]         bcnt, bcnt_nxt;
  logic                  busy_nxt, done_nxt, sclk_nxt, sync_n_nxt, sdo_nxt;

  // State and all registered outputs; reset returns the pins to their idle levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      hcnt   <= '0;
      bcnt   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sclk   <= 1'b1;
      sync_n <= 1'b1;
      sdo    <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      hcnt   <= hcnt_nxt;
      bcnt   <= bcnt_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      sclk   <= sclk_nxt;
      sync_n <= sync_n_nxt;
      sdo    <= sdo_nxt;
    end
  end

  // Next state and next output values. bcnt counts falling edges issued so far;
  // the frame ends when a high half finishes after the last falling edge.
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    hcnt_nxt   = hcnt;
    bcnt_nxt   = bcnt;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    sclk_nxt   = sclk;
    sync_n_nxt = sync_n;
    sdo_nxt    = sdo;
    case (state)
      IDLE: begin
        busy_nxt   = 1'b0;
        sclk_nxt   = 1'b1;
        sync_n_nxt = 1'b1;
        sdo_nxt    = 1'b0;
        hcnt_nxt   = '0;
        bcnt_nxt   = '0;
        if (start) begin
          state_nxt  = SHIFT;
          shreg_nxt  = din;
          busy_nxt   = 1'b1;
          sync_n_nxt = 1'b0;
          sdo_nxt    = din[DATA_WIDTH-1];
        end
      end
      SHIFT: begin
        if (hcnt == HLAST) begin
          hcnt_nxt = '0;
          if (sclk) begin
            if (bcnt == BLAST) begin
              // Final high half complete: release SYNC and flag the frame done.
              state_nxt  = DONE;
              sync_n_nxt = 1'b1;
              sdo_nxt    = 1'b0;
              done_nxt   = 1'b1;
            end else begin
              sclk_nxt = 1'b0;
              bcnt_nxt = bcnt + 1'b1;
            end
          end else begin
            sclk_nxt = 1'b1;
            // Advance to the next bit on the rising edge; the last bit is held for hold time.
            if (bcnt != BLAST) begin
              shreg_nxt = {shreg[DATA_WIDTH-2:0], 1'b0};
              sdo_nxt   = shreg[DATA_WIDTH-2];
            end
          end
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        bcnt_nxt  = '0;
        hcnt_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef DAC_SPI_TX_FRAME_COUNT_EN
  // Count completed frames; an aborted frame never reaches the done cycle so it is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (done) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx: default instance (16-bit, SCLK_DIV=4) plus an 8-bit, SCLK_DIV=1 instance.
// Expected words are queued when a start is driven and compared against bits sampled on sclk falling edges.
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] din = '0;
  logic        busy, done, sclk, sync_n, sdo;
  logic        start1 = 1'b0;
  logic [7:0]  din1 = '0;
  logic        busy1, done1, sclk1, sync_n1, sdo1;
`ifdef DAC_SPI_TX_FRAME_COUNT_EN
  logic [15:0] frame_cnt, frame_cnt1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dac_spi_tx u0 (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .busy(busy), .done(done), .sclk(sclk), .sync_n(sync_n), .sdo(sdo)
`ifdef DAC_SPI_TX_FRAME_COUNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  dac_spi_tx #(.DATA_WIDTH(8), .SCLK_DIV(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .din(din1),
    .busy(busy1), .done(done1), .sclk(sclk1), .sync_n(sync_n1), .sdo(sdo1)
`ifdef DAC_SPI_TX_FRAME_COUNT_EN
    , .frame_cnt(frame_cnt1)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard for u0 ----------------
  logic [15:0] sb_q[$];
  logic [15:0] accum = '0;
  logic [15:0] expw;
  int falls = 0, blen = 0, gap_err = 0, last_fall = -1, cyc = 0;
  int hi_run = 0, last_gap = 0, done_total = 0;
  logic p_sclk = 1'b1, p_sync = 1'b1, p_busy = 1'b0, p_done = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      accum = '0; falls = 0; blen = 0; gap_err = 0; last_fall = -1; hi_run = 0;
    end else begin
      if (busy) blen++;
      if (p_sclk && !sclk && !sync_n) begin
        accum = {accum[14:0], sdo};
        if (last_fall >= 0 && (cyc - last_fall) != 8) gap_err++;
        last_fall = cyc;
        falls++;
      end
      if (p_sync && !sync_n) begin
        last_gap = hi_run;
        hi_run = 0;
      end
      if (sync_n) hi_run++;
      if (!p_sync && sync_n) begin
        if (sb_q.size() > 0) expw = sb_q.pop_front();
        else expw = 'x;
        check("frame_word", accum, expw);
        check("fall_count", falls, 16);
        check("sclk_period", gap_err, 0);
        check("done_with_sync_rise", done, 1'b1);
        falls = 0; gap_err = 0; last_fall = -1; accum = '0;
      end
      if (p_busy && !busy) begin
        check("busy_len", blen, 133);
        blen = 0;
      end
      if (done) done_total++;
      if (p_done) check("done_one_cycle", done, 1'b0);
    end
    p_sclk = sclk; p_sync = sync_n; p_busy = busy; p_done = done;
  end

  // ---------------- simple monitor for u1 ----------------
  int b1len = 0, falls1 = 0;
  logic [7:0] bits1 = '0;
  logic p_sclk1 = 1'b1;
  always @(negedge clk) begin
    if (busy1) b1len++;
    if (p_sclk1 && !sclk1 && !sync_n1) begin
      bits1 = {bits1[6:0], sdo1};
      falls1++;
    end
    p_sclk1 = sclk1;
  end

  task automatic wait_busy(input logic lvl, input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (busy == lvl) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check(nm, ok, 1'b1);
  endtask

  task automatic run_frame(input logic [15:0] w, input logic [15:0] late_w, input int late_at,
                           input logic [15:0] exp_w);
    int d0;
    d0 = done_total;
    start = 1'b1; din = w;
    sb_q.push_back(exp_w);
    tick();
    start = 1'b0; din = ~w;
    check("accept_sync_low", sync_n, 1'b0);
    if (late_at > 0) begin
      repeat (late_at - 1) tick();
      start = 1'b1; din = late_w;
      tick();
      start = 1'b0;
    end
    wait_busy(1'b0, "frame_timeout");
    repeat (5) tick();
    check("one_done_per_frame", done_total - d0, 1);
  endtask

  typedef struct {
    logic [15:0] din;
    logic [15:0] late_din;
    int          late_at;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs[4];
  logic [15:0] alt;
  int d0;

  initial begin
    vecs[0] = '{16'hA5C3, 16'h0000, 0,  16'hA5C3};
    vecs[1] = '{16'h0001, 16'hFFFF, 40, 16'h0001};
    vecs[2] = '{16'h8000, 16'h0000, 0,  16'h8000};
    vecs[3] = '{16'h7FFE, 16'h1234, 90, 16'h7FFE};

    // Reset: hold 5 cycles, then idle outputs for 20 cycles with no start.
    repeat (5) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_outputs", {busy, done, sclk, sync_n, sdo}, 5'b00110);
    end
`ifdef DAC_SPI_TX_FRAME_COUNT_EN
    check("frame_cnt_reset", frame_cnt, 16'd0);
`endif

    // Table-driven single frames (including ignored start while busy).
    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].din, vecs[v].late_din, vecs[v].late_at, vecs[v].exp_word);
    end

    // Continuous start with alternating words: 2-cycle sync_n gap between frames.
    start = 1'b1; din = 16'h0F0F; alt = 16'h0F0F;
    sb_q.push_back(16'h0F0F);
    for (int k = 0; k < 4; k++) begin
      wait_busy(1'b1, "cont_start_timeout");
      if (k < 3) begin
        alt = ~alt;
        din = alt;
        sb_q.push_back(alt);
      end else begin
        start = 1'b0;
      end
      wait_busy(1'b0, "cont_end_timeout");
      if (k >= 1) check("sync_gap", last_gap, 2);
    end
    repeat (5) tick();

    // Mid-frame reset 60 cycles into a frame: no done, outputs at reset values.
    d0 = done_total;
    start = 1'b1; din = 16'h3C3C;
    sb_q.push_back(16'h3C3C);
    tick();
    start = 1'b0;
    repeat (59) tick();
    rst = 1'b1;
    tick();
    check("abort_outputs", {busy, done, sclk, sync_n, sdo}, 5'b00110);
    tick();
    rst = 1'b0;
    if (sb_q.size() > 0) expw = sb_q.pop_front();
    repeat (140) tick();
    check("abort_no_done", done_total - d0, 0);
    run_frame(16'h1234, 16'h0000, 0, 16'h1234);

    // 8-bit, SCLK_DIV=1 instance.
`ifdef DAC_SPI_TX_FRAME_COUNT_EN
    check("frame_cnt1_before", frame_cnt1, 16'd0);
`endif
    b1len = 0; falls1 = 0; bits1 = '0;
    start1 = 1'b1; din1 = 8'h81;
    tick();
    start1 = 1'b0; din1 = 8'h00;
    begin
      logic ok1;
      ok1 = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (done1) begin
          ok1 = 1'b1;
          break;
        end
        tick();
      end
      check("u1_done_seen", ok1, 1'b1);
    end
    repeat (3) tick();
    check("u1_busy_len", b1len, 18);
    check("u1_falls", falls1, 8);
    check("u1_bits", bits1, 8'h81);
`ifdef DAC_SPI_TX_FRAME_COUNT_EN
    check("frame_cnt1_after", frame_cnt1, 16'd1);
`endif

    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
